router_ingress_buf: RTL and testbench
=====================================

Name: router_ingress_buf

Overview:
- Ingress buffer directly upstream of the 4-port router.
- Accepts (addr, data) words on a valid/ready interface and stores them in a DEPTH-entry circular FIFO.
- Presents one word per cycle to the router as data_en/addr/data_in, and honours a downstream stall.
- Words whose address exceeds the router's port count are accepted, discarded and counted.

Parameters:
- DATA_WIDTH, 32, width of payload word; matches router data_in.
- ADDR_WIDTH, 2, width of port address; matches router addr.
- NUM_PORTS, 4, number of valid router ports; addresses >= NUM_PORTS are dropped.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  buffer can accept; equals !full (registered state, no combinational path from out_stall).
- in_data  in  DATA_WIDTH  upstream payload.
- in_addr  in  ADDR_WIDTH  destination port.
- out_en  out  1  drives router data_en; one-cycle pulse per delivered word.
- out_data  out  DATA_WIDTH  drives router data_in.
- out_addr  out  ADDR_WIDTH  drives router addr.
- out_stall  in  1  downstream not consuming; no pop while high.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  16  saturating count of dropped out-of-range words.

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - out_en=0, out_data=0, out_addr=0, count=0, drop_cnt=0, in_ready=1.
  - Read/write pointers are 0; FIFO contents are don't-care.
  - Reset mid-operation discards all buffered words; no partial delivery after release.
- Accept: in_valid && in_ready at a rising edge.
  - Address in range: write {in_addr, in_data} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
  - in_addr >= NUM_PORTS: handshake completes, nothing is written, drop_cnt += 1 (saturates at 0xFFFF).
  - When NUM_PORTS == 2^ADDR_WIDTH, no drops are possible.
- Pop: at each edge where count != 0 and out_stall == 0:
  - Load out_data/out_addr from rd_ptr and set out_en=1; rd_ptr wraps.
  - Otherwise out_en=0 next cycle.
- Output hold: out_data/out_addr keep their last popped value while out_en=0. The router ignores them when data_en is low.
- Latency: a word accepted at edge N is popped at edge N+1 at the earliest, so out_en is high in the cycle after edge N+1. Minimum latency is 2 cycles when the FIFO is empty.
- Throughput: one word per cycle in steady state with out_stall=0.
- Simultaneous push+pop: count is unchanged. Allowed at any occupancy except full, where in_ready=0 blocks the push even if a pop occurs the same cycle.
- Full (count == DEPTH): in_ready=0, and in_valid is ignored.
- Empty (count == 0): no pop, out_en=0. A push to the empty FIFO is not bypassed.
- Stall: out_stall is sampled at the edge. If high, out_en=0 next cycle and there is no pop. A word already presented (out_en=1) is considered delivered; the stall does not retract it.
- Order: strict FIFO; dropped words do not disturb the order of the others.

Optional Feature:
- Macro: ROUTER_INGRESS_HWM_EN
- Defined:
  - Adds output hwm ($clog2(DEPTH)+1 bits) = maximum count observed since reset; updates the edge after count rises; reset to 0.
  - Adds input hwm_clr (1 bit); synchronous clear to the current count. A clear coincident with a new maximum loads the new count.
- Undefined: neither port exists; no HWM logic is generated. Core behaviour is identical.

Test Plan:
- Reset then single word: in_addr=2, in_data=0xDEADBEEF accepted at edge 1 -> out_en=1 with out_addr=2, out_data=0xDEADBEEF in the cycle after edge 2, for exactly one cycle; count returns to 0.
- Fill to full: 8 back-to-back words, data 0..7, addr = i%4, out_stall=1 -> count=8, in_ready=0, a 9th word is not accepted. Release the stall -> 8 consecutive out_en pulses, data 0..7 in order.
- Wrap-around: 20 words streamed with out_stall toggling every 3 cycles -> all 20 delivered in order, no loss or duplication, count never exceeds 8.
- Drop: NUM_PORTS=3, words with addr 3,0,3 -> drop_cnt=2, only the addr-0 word is delivered. Pre-load drop_cnt at 0xFFFF via a long drop stream -> it stays at 0xFFFF.
- Simultaneous push/pop: count=4, push and pop in the same cycle -> count stays 4; the popped word is the oldest.
- Async reset mid-stream: assert rst_n=0 with count=5 and out_en=1 -> out_en, count and drop_cnt go to 0 immediately. After release, an empty FIFO gives no out_en; with ROUTER_INGRESS_HWM_EN defined, hwm=0.

Source files
------------

// File: rtl/router_ingress_buf_if.sv
// Handshake bundle between the upstream source, the ingress buffer and the
// router input. The buffer takes the slave view; the environment driving words
// in and watching the router side takes the master view.
interface router_ingress_buf_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  out_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_stall;

  modport slave (
    input  in_valid, in_data, in_addr, out_stall,
    output in_ready, out_en, out_data, out_addr
  );

  modport master (
    output in_valid, in_data, in_addr, out_stall,
    input  in_ready, out_en, out_data, out_addr
  );
endinterface

// File: rtl/router_ingress_buf.sv
// Ingress buffer in front of the 4-port router: a DEPTH-entry circular FIFO of
// {addr, data} words with valid/ready input and a stallable one-word-per-cycle
// output. Out-of-range addresses are accepted, discarded and counted.
// Optional high-water-mark tracking is enabled with ROUTER_INGRESS_HWM_EN.
module router_ingress_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_PORTS  = 4,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  router_ingress_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_cnt
`ifdef ROUTER_INGRESS_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]     hwm,
  input  logic                       hwm_clr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage has no reset so it can map onto RAM; only pointers/counters reset.
  logic [EW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [15:0]           drop_q, drop_d;
  logic                  out_en_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;

  logic in_range;
  logic accept;
  logic push;
  logic drop;
  logic pop;

  // When every address value names a real port, no range compare is needed.
  if (NUM_PORTS >= (1 << ADDR_WIDTH)) begin : g_all_in_range
    assign in_range = 1'b1;
  end else begin : g_range_check
    assign in_range = ({1'b0, bus.in_addr} < (ADDR_WIDTH+1)'(NUM_PORTS));
  end

  // in_ready depends only on registered occupancy, never on out_stall.
  assign bus.in_ready = (count_q != FULL_CNT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && in_range;
  assign drop         = accept && !in_range;
  assign pop          = (count_q != '0) && !bus.out_stall;

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    drop_d   = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_addr, bus.in_data};
    end
  end

  // Control state and registered router outputs; outputs hold between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      out_en_q <= pop;
      if (pop) begin
        {out_addr_q, out_data_q} <= mem_q[rd_ptr_q];
      end
    end
  end

  assign bus.out_en   = out_en_q;
  assign bus.out_data = out_data_q;
  assign bus.out_addr = out_addr_q;
  assign count        = count_q;
  assign drop_cnt     = drop_q;

`ifdef ROUTER_INGRESS_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  // Clear reloads the present occupancy, which is also the new maximum if any.
  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr || (count_q > hwm_q)) begin
      hwm_d = count_q;
    end
  end

  // High-water-mark register, trailing count by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_router_ingress_buf.sv
// Directed bench for router_ingress_buf: a default instance (4 ports) and a
// 3-port instance for the drop path, both on one clock and reset.
`timescale 1ns/1ps
module tb_router_ingress_buf;

  logic clk;
  logic rst_n;
  logic [3:0]  a_count, b_count;
  logic [15:0] a_drop, b_drop;
`ifdef ROUTER_INGRESS_HWM_EN
  logic [3:0] a_hwm, b_hwm;
  logic       a_hwm_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  router_ingress_buf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) a_if ();
  router_ingress_buf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) b_if ();

  router_ingress_buf #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .NUM_PORTS(4), .DEPTH(8)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (a_if),
    .count    (a_count),
    .drop_cnt (a_drop)
`ifdef ROUTER_INGRESS_HWM_EN
    ,
    .hwm      (a_hwm),
    .hwm_clr  (a_hwm_clr)
`endif
  );

  router_ingress_buf #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .NUM_PORTS(3), .DEPTH(8)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b_if),
    .count    (b_count),
    .drop_cnt (b_drop)
`ifdef ROUTER_INGRESS_HWM_EN
    ,
    .hwm      (b_hwm),
    .hwm_clr  (1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [33:0] exp_q [$];
  logic [33:0] exp_w;
  int          sent, got, cyc, max_cnt;
  logic        rdy;
  logic [1:0]  drop_addr [3];
  logic [31:0] drop_data [3];

  initial begin
    rst_n = 1'b0;
    a_if.in_valid = 0; a_if.in_data = '0; a_if.in_addr = '0; a_if.out_stall = 0;
    b_if.in_valid = 0; b_if.in_data = '0; b_if.in_addr = '0; b_if.out_stall = 0;
`ifdef ROUTER_INGRESS_HWM_EN
    a_hwm_clr = 0;
`endif
    #12;
    check("reset out_en",   a_if.out_en,   0);
    check("reset out_data", a_if.out_data, 0);
    check("reset out_addr", a_if.out_addr, 0);
    check("reset count",    a_count,       0);
    check("reset drop_cnt", b_drop,        0);
    check("reset in_ready", a_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word: accepted at edge 1, presented after edge 2 for one cycle.
    a_if.in_valid = 1; a_if.in_addr = 2; a_if.in_data = 32'hDEADBEEF;
    step();
    a_if.in_valid = 0;
    check("single count after push", a_count, 1);
    check("single no bypass",        a_if.out_en, 0);
    step();
    check("single out_en",   a_if.out_en,   1);
    check("single out_addr", a_if.out_addr, 2);
    check("single out_data", a_if.out_data, 32'hDEADBEEF);
    check("single count 0",  a_count,       0);
    step();
    check("single pulse ends", a_if.out_en, 0);
    check("single data held",  a_if.out_data, 32'hDEADBEEF);

    // Fill to full under stall, then drain in order.
    a_if.out_stall = 1;
    for (int i = 0; i < 8; i++) begin
      a_if.in_valid = 1; a_if.in_data = i; a_if.in_addr = i % 4;
      step();
    end
    check("fill count 8",   a_count,       8);
    check("fill in_ready 0", a_if.in_ready, 0);
    a_if.in_data = 32'h99; a_if.in_addr = 1;
    step();
    a_if.in_valid = 0;
    check("fill 9th rejected", a_count, 8);
    check("fill stalled out_en", a_if.out_en, 0);
`ifdef ROUTER_INGRESS_HWM_EN
    check("hwm at full", a_hwm, 8);
`endif
    a_if.out_stall = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("drain out_en %0d", i), a_if.out_en, 1);
      check($sformatf("drain word %0d", i), {a_if.out_addr, a_if.out_data}, {2'(i % 4), 32'(i)});
    end
    step();
    check("drain done out_en", a_if.out_en, 0);
    check("drain done count",  a_count,     0);
`ifdef ROUTER_INGRESS_HWM_EN
    check("hwm held after drain", a_hwm, 8);
    a_hwm_clr = 1;
    step();
    a_hwm_clr = 0;
    check("hwm cleared to count", a_hwm, 0);
`endif

    // Wrap-around stream with stall toggling every 3 cycles.
    sent = 0; got = 0; cyc = 0; max_cnt = 0;
    while (got < 20 && cyc < 400) begin
      a_if.out_stall = ((cyc / 3) % 2) == 1;
      a_if.in_valid  = (sent < 20);
      a_if.in_data   = 32'h5000 + sent;
      a_if.in_addr   = 2'(sent % 4);
      rdy = a_if.in_ready;
      step();
      cyc++;
      if (a_if.in_valid && rdy) begin
        exp_q.push_back({a_if.in_addr, a_if.in_data});
        sent++;
      end
      if (a_if.out_en) begin
        if (exp_q.size() == 0) begin
          check("wrap spurious out_en", a_if.out_en, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check($sformatf("wrap word %0d", got), {a_if.out_addr, a_if.out_data}, exp_w);
        end
        got++;
      end
      if (int'(a_count) > max_cnt) max_cnt = int'(a_count);
    end
    a_if.in_valid = 0; a_if.out_stall = 0;
    check("wrap delivered", got, 20);
    check("wrap count le 8", (max_cnt <= 8), 1);
    step();
    check("wrap empty", a_count, 0);

    // Simultaneous push and pop at count 4.
    a_if.out_stall = 1;
    for (int i = 0; i < 4; i++) begin
      a_if.in_valid = 1; a_if.in_data = 32'h100 + i; a_if.in_addr = 1;
      step();
    end
    check("pp count 4", a_count, 4);
    a_if.out_stall = 0; a_if.in_data = 32'h200; a_if.in_addr = 3;
    step();
    a_if.in_valid = 0;
    check("pp count stays 4", a_count, 4);
    check("pp oldest popped", a_if.out_data, 32'h100);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("pp drain %0d", i), {a_if.out_addr, a_if.out_data},
            (i < 3) ? {2'd1, 32'h101 + 32'(i)} : {2'd3, 32'h200});
    end
    step();
    check("pp drained", a_count, 0);

    // Drops on the 3-port instance.
    drop_addr[0] = 3; drop_addr[1] = 0; drop_addr[2] = 3;
    drop_data[0] = 32'hA1; drop_data[1] = 32'hB2; drop_data[2] = 32'hC3;
    for (int i = 0; i < 3; i++) begin
      b_if.in_valid = 1; b_if.in_addr = drop_addr[i]; b_if.in_data = drop_data[i];
      step();
    end
    b_if.in_valid = 0;
    check("drop cnt 2",      b_drop,        2);
    check("drop kept out_en", b_if.out_en,  1);
    check("drop kept word",  {b_if.out_addr, b_if.out_data}, {2'd0, 32'hB2});
    step();
    check("drop only one delivered", b_if.out_en, 0);
    check("drop count 0", b_count, 0);
    b_if.in_valid = 1; b_if.in_addr = 3; b_if.in_data = 32'hEE;
    repeat (65540) step();
    b_if.in_valid = 0;
    check("drop saturates", b_drop, 16'hFFFF);
    check("drop never stored", b_count, 0);

    // Async reset mid-stream with count 5 and out_en high.
    a_if.out_stall = 1;
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = 1; a_if.in_data = 32'h300 + i; a_if.in_addr = 0;
      step();
    end
    a_if.out_stall = 0; a_if.in_data = 32'h305;
    step();
    a_if.in_valid = 0;
    check("pre-reset count 5",  a_count,     5);
    check("pre-reset out_en 1", a_if.out_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_en",   a_if.out_en, 0);
    check("async rst count",    a_count,     0);
    check("async rst drop_cnt", b_drop,      0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("post-reset out_en",   a_if.out_en,   0);
    check("post-reset count",    a_count,       0);
    check("post-reset in_ready", a_if.in_ready, 1);
`ifdef ROUTER_INGRESS_HWM_EN
    check("post-reset hwm", a_hwm, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
